// File: rtl/remote_transmitter.sv
// Serializes an 8-bit key into a 32-bit IR remote frame {0, HEADER, key, ~key} on an idle-high line.
// Optional one-entry request buffer enabled by defining REMOTE_TX_BUFFER_EN.
module remote_transmitter #(
    parameter int          BIT_CLKS   = 8,
    parameter logic [14:0] HEADER     = 15'h5AA5,
    parameter int          GUARD_BITS = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Tecla,
    input  logic       Send,
    output logic       Serial,
    output logic       Busy,
    output logic       Done
);
    localparam int BAUD_W = $clog2(BIT_CLKS);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BIT_CLKS - 1);
    localparam logic [5:0]        GUARD_LAST = 6'(GUARD_BITS - 1);
    localparam logic [5:0]        FRAME_LAST = 6'd31;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SEND  = 2'd1;
    localparam logic [1:0] GUARD = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [31:0]       shreg_q, shreg_d;
    logic [5:0]        bitcnt_q, bitcnt_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              baud_wrap, guard_end;
`ifdef REMOTE_TX_BUFFER_EN
    logic [7:0]        buf_key_q, buf_key_d;
    logic              buf_vld_q, buf_vld_d;
`endif

    function automatic logic [31:0] frame_word(input logic [7:0] k);
        return {1'b0, HEADER, k, ~k};
    endfunction

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign guard_end = (state_q == GUARD) && baud_wrap && (bitcnt_q == GUARD_LAST);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        baud_d   = baud_q;
        serial_d = 1'b1;
        busy_d   = 1'b1;
        done_d   = 1'b0;
`ifdef REMOTE_TX_BUFFER_EN
        buf_key_d = buf_key_q;
        buf_vld_d = buf_vld_q;
        // Park a request that arrives mid-frame; the last guard cycle is handled below.
        if (((state_q == SEND) || ((state_q == GUARD) && !guard_end)) && Send && !buf_vld_q) begin
            buf_key_d = Tecla;
            buf_vld_d = 1'b1;
        end
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (Send) begin
                    shreg_d  = frame_word(Tecla);
                    bitcnt_d = '0;
                    baud_d   = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                serial_d = shreg_q[31];
                if (baud_wrap) begin
                    baud_d   = '0;
                    shreg_d  = {shreg_q[30:0], 1'b0};
                    bitcnt_d = bitcnt_q + 6'd1;
                    if (bitcnt_q == FRAME_LAST) begin
                        bitcnt_d = '0;
                        state_d  = GUARD;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            GUARD: begin
                if (baud_wrap) begin
                    baud_d   = '0;
                    bitcnt_d = bitcnt_q + 6'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
                if (guard_end) begin
                    done_d   = 1'b1;
                    bitcnt_d = '0;
                    state_d  = IDLE;
`ifdef REMOTE_TX_BUFFER_EN
                    // Chain straight into the next frame so Busy never drops.
                    if (buf_vld_q) begin
                        shreg_d   = frame_word(buf_key_q);
                        buf_vld_d = 1'b0;
                        state_d   = SEND;
                    end else if (Send) begin
                        shreg_d = frame_word(Tecla);
                        state_d = SEND;
                    end
`endif
                end
            end
            default: begin
                state_d  = IDLE;
                shreg_d  = '0;
                bitcnt_d = '0;
                baud_d   = '0;
                busy_d   = 1'b0;
`ifdef REMOTE_TX_BUFFER_EN
                buf_key_d = '0;
                buf_vld_d = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            baud_q   <= '0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef REMOTE_TX_BUFFER_EN
            buf_key_q <= '0;
            buf_vld_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            baud_q   <= baud_d;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef REMOTE_TX_BUFFER_EN
            buf_key_q <= buf_key_d;
            buf_vld_q <= buf_vld_d;
`endif
        end
    end

    assign Serial = serial_q;
    assign Busy   = busy_q;
    assign Done   = done_q;
endmodule

// File: tb/tb_remote_transmitter.sv
// Bench for remote_transmitter: constant table for the basic frame, frame decoding,
// and a cycle-timeline reference model checked on every clock under random stimulus.
module tb_remote_transmitter;
    localparam logic [14:0] HDR  = 15'h5AA5;
    localparam int          LOGN = 8192;

    logic       Clock = 1'b0;
    logic       Reset, Send;
    logic [7:0] Tecla;
    logic       Serial, Busy, Done;

    remote_transmitter #(.BIT_CLKS(8), .HEADER(HDR), .GUARD_BITS(2)) dut (
        .Clock(Clock), .Reset(Reset), .Tecla(Tecla), .Send(Send),
        .Serial(Serial), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int   rel;
        logic ser;
        logic bsy;
        logic dn;
    } vec_t;

    vec_t tbl[16];
    int   vectors = 0, miscompares = 0, cyc = 0;
    logic ser_log[LOGN], bsy_log[LOGN], dn_log[LOGN];

    // Reference model: a frame is a timeline relative to its accept edge.
    int         m_start = -1;
    logic [7:0] m_key = '0, m_bk = '0;
    logic       m_bv = 1'b0;

    function automatic logic [31:0] frame(input logic [7:0] k);
        return {1'b0, HDR, k, ~k};
    endfunction

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got ser/busy/done=%b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [7:0] k);
        int d;
        logic [2:0] exp;
        logic [31:0] w;
        Reset = r; Send = s; Tecla = k;
        @(posedge Clock);
        cyc++;
        #1;
        if (!r) begin
            exp = 3'b100;
            m_start = -1;
            m_bv = 1'b0;
        end else begin
            d = (m_start < 0) ? 100000 : cyc - m_start;
            w = frame(m_key);
            if (d >= 1 && d <= 272)
                exp = {(d <= 256) ? w[31 - (d - 1) / 8] : 1'b1, 1'b1, d == 272};
            else
                exp = 3'b100;
            if (d >= 273) begin
                if (s) begin m_start = cyc; m_key = k; end
            end
`ifdef REMOTE_TX_BUFFER_EN
            else if (d == 272) begin
                if (m_bv) begin m_start = cyc; m_key = m_bk; m_bv = 1'b0; end
                else if (s) begin m_start = cyc; m_key = k; end
            end else if (s && !m_bv) begin
                m_bk = k; m_bv = 1'b1;
            end
`endif
        end
        if (cyc < LOGN) begin
            ser_log[cyc] = Serial; bsy_log[cyc] = Busy; dn_log[cyc] = Done;
        end
        check("model", {Serial, Busy, Done}, exp);
    endtask

    // Mid-bit sampling of a logged frame, as the receiver would see it.
    task automatic decode_check(input string name, input int base, input logic [7:0] k);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[31 - i] = ser_log[base + 5 + 8 * i];
        vectors++;
        if (w !== frame(k)) begin
            miscompares++;
            $display("FAIL %s got word=%h want %h", name, w, frame(k));
        end
    endtask

    task automatic send_frame(input logic [7:0] k, input logic [7:0] after_k, input int n, output int base);
        base = cyc + 1;
        step(1'b1, 1'b1, k);
        repeat (n) step(1'b1, 1'b0, after_k);
    endtask

    initial begin
        int b;
        logic r, s;
        tbl = '{
            '{0,   1'b1, 1'b0, 1'b0}, '{1,   1'b0, 1'b1, 1'b0}, '{8,   1'b0, 1'b1, 1'b0},
            '{9,   1'b1, 1'b1, 1'b0}, '{16,  1'b1, 1'b1, 1'b0}, '{17,  1'b0, 1'b1, 1'b0},
            '{121, 1'b1, 1'b1, 1'b0}, '{129, 1'b0, 1'b1, 1'b0}, '{137, 1'b1, 1'b1, 1'b0},
            '{193, 1'b1, 1'b1, 1'b0}, '{249, 1'b0, 1'b1, 1'b0}, '{256, 1'b0, 1'b1, 1'b0},
            '{257, 1'b1, 1'b1, 1'b0}, '{271, 1'b1, 1'b1, 1'b0}, '{272, 1'b1, 1'b1, 1'b1},
            '{273, 1'b1, 1'b0, 1'b0}
        };

        // Reset state
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("reset", {Serial, Busy, Done}, 3'b100);

        // Basic frame against the constant table
        send_frame(8'h45, 8'h45, 280, b);
        for (int i = 0; i < 16; i++)
            check($sformatf("basic_rel%0d", tbl[i].rel),
                  {ser_log[b + tbl[i].rel], bsy_log[b + tbl[i].rel], dn_log[b + tbl[i].rel]},
                  {tbl[i].ser, tbl[i].bsy, tbl[i].dn});
        decode_check("basic_decode", b, 8'h45);

        // Key change right after accept
        send_frame(8'h45, 8'hFF, 280, b);
        decode_check("key_change", b, 8'h45);

        // Loopback-style decodes for several keys
        send_frame(8'hC3, 8'hC3, 280, b); decode_check("loop_c3", b, 8'hC3);
        send_frame(8'h00, 8'h00, 280, b); decode_check("loop_00", b, 8'h00);
        send_frame(8'hFF, 8'hFF, 280, b); decode_check("loop_ff", b, 8'hFF);

        // Requests while busy: 34 at rel 100, 56 at rel 150
        b = cyc + 1;
        step(1'b1, 1'b1, 8'h12);
        for (int i = 1; i < 600; i++)
            step(1'b1, (i == 100) || (i == 150), (i == 100) ? 8'h34 : (i == 150) ? 8'h56 : 8'h12);
        decode_check("busy_first", b, 8'h12);
`ifdef REMOTE_TX_BUFFER_EN
        check("buf_no_gap", {ser_log[b + 273], bsy_log[b + 273], dn_log[b + 273]}, 3'b010);
        decode_check("buf_second", b + 272, 8'h34);
        check("buf_drop_third", {ser_log[b + 545], bsy_log[b + 545], dn_log[b + 545]}, 3'b100);
`else
        check("busy_reject", {ser_log[b + 273], bsy_log[b + 273], dn_log[b + 273]}, 3'b100);
        check("busy_reject_late", {ser_log[b + 400], bsy_log[b + 400], dn_log[b + 400]}, 3'b100);
`endif

        // Reset mid-frame while the line is low
        b = cyc + 1;
        step(1'b1, 1'b1, 8'hA5);
        repeat (120) step(1'b1, 1'b0, 8'hA5);
        check("pre_reset_low", {ser_log[b + 120], bsy_log[b + 120], dn_log[b + 120]}, 3'b010);
        step(1'b0, 1'b0, 8'hA5);
        check("mid_reset", {Serial, Busy, Done}, 3'b100);
        step(1'b1, 1'b0, 8'hA5);
        send_frame(8'hA5, 8'hA5, 280, b);
        decode_check("after_reset", b, 8'hA5);

        // Random traffic against the model
        for (int i = 0; i < 2500; i++) begin
            r = ($urandom_range(0, 599) != 0);
            s = ($urandom_range(0, 39) == 0);
            step(r, s, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/remote_transmitter.md
# remote_transmitter

- Serializes an 8-bit key code into the 32-bit-period infrared remote frame consumed by the remote-controller receiver.
- Frame: start bit, 15-bit header, key, bitwise-inverted key.
- Placement: sits on the same 304 kHz clock domain and drives the shared idle-high `Serial` line at 38 kHz bit rate (8 clocks per bit).
- Exists to generate test frames and to act as the key-sender side of the link.

## Interface

Parameters:

- `BIT_CLKS`, 8: clocks per bit period; must be ≥2.
- `HEADER`, 15'h5AA5: fixed header bits, sent MSB first after the start bit.
- `GUARD_BITS`, 2: idle-high bit periods after the frame before the next frame; must be ≥1.

Ports:

- `Clock`, input, 1: 304 kHz system clock, rising-edge.
- `Reset`, input, 1: synchronous, active-low; 0 at a rising `Clock` edge resets the block.
- `Tecla`, input, 8: key code to send; sampled only on accept.
- `Send`, input, 1: request. Level-sampled each cycle; acceptance rules are in Operation.
- `Serial`, output, 1: registered line output; idle 1.
- `Busy`, output, 1: registered; 1 while a frame or guard is in progress.
- `Done`, output, 1: registered; one-cycle pulse in the last guard cycle.

## Operation

- Reset values: `Serial`=1, `Busy`=0, `Done`=0, state IDLE, all counters 0, holding buffer empty.
- Frame word is 32 bits, transmitted MSB first: {1'b0, HEADER[14:0], K[7:0], ~K[7:0]}. K is the `Tecla` value latched at accept.
- State IDLE:
  - `Serial`=1 and `Busy`=0.
  - `Send`=1 means accept: latch the frame word into a 32-bit shift register, clear the bit counter (6-bit) and the baud counter, and go to SEND.
- State SEND:
  - `Serial` = shift register MSB.
  - The baud counter counts 0..BIT_CLKS-1. At BIT_CLKS-1 it wraps to 0, shifts left by 1 and increments the bit counter.
  - After the 32nd bit period completes, go to GUARD.
- State GUARD:
  - `Serial`=1 for GUARD_BITS×BIT_CLKS cycles.
  - `Done`=1 in the final cycle, then go to IDLE.
- `Send` while `Busy`=1: ignored unless the macro below is defined.
- `Tecla` changes after accept have no effect on the frame in flight.
- Reset low mid-frame: on that edge the outputs take their reset values. Any buffered request is discarded; no partial frame continues.
- Illegal or unused state encodings go to IDLE with reset output values.

## Timing

- Let accept occur at rising edge N, i.e. `Send`=1 sampled in IDLE.
- `Serial` goes low and `Busy` goes high at edge N+1.
- Bit i (0 = start bit) is driven for cycles N+1+i×BIT_CLKS through N+(i+1)×BIT_CLKS.
- The frame occupies 32×BIT_CLKS cycles; the default is 256.
- `Done`=1 and the last `Busy`=1 occur in cycle N+(32+GUARD_BITS)×BIT_CLKS, which is 272 at defaults.
- `Busy` is 0 in the following cycle. The earliest next accept is at that cycle's edge.
- The receiver samples mid-bit, so bit 0 must be a full low period. `Serial` is glitch-free because it is driven from a flop.

## Configuration

- Macro: `REMOTE_TX_BUFFER_EN`.
- Defined: adds a one-entry holding buffer (8-bit key plus valid flag).
  - `Send`=1 while `Busy`=1 with the buffer empty latches `Tecla` into the buffer.
  - `Send` with the buffer full is ignored; the first buffered key is kept.
  - On the cycle `Done`=1, a valid buffer is loaded as the next frame. Because it is loaded in that same cycle, SEND starts with no IDLE cycle: `Busy` stays 1 and `Serial` goes low on the next edge.
  - The buffer is cleared on load.
  - `Send` in the `Done` cycle with the buffer empty is treated as a direct accept.
- Not defined:
  - No buffer logic is compiled in.
  - `Send` is honoured only in IDLE.

## Test plan

- Basic frame: reset low 2 cycles, then `Tecla`=8'h45 with a 1-cycle `Send`. Required response:
  - `Serial` = 0 for 8 cycles.
  - Then 15'h5AA5, then 8'h45, then 8'hBA, each bit 8 cycles.
  - Then 16 cycles high, with `Done` at cycle 272 and `Busy` low at cycle 273.
- Loopback into the remote-controller receiver with `Tecla`=8'hC3: the receiver must output `Tecla`=8'hC3 with `Ready` high for 4 cycles. Repeat for 8'h00 and 8'hFF.
- Busy rejection (macro off): send 8'h12, pulse `Send` with 8'h34 at cycle 100. Required response: exactly one frame (8'h12), and `Busy` stays low after cycle 273.
- Buffering (macro on): send 8'h12, pulse 8'h34 at cycle 100, then 8'h56 at cycle 150. Required response:
  - Frames 8'h12 then 8'h34, back to back, with no `Busy` gap.
  - The second frame starts at cycle 273.
  - 8'h56 is never sent.
- Reset mid-frame: assert reset at cycle 120 while `Serial`=0. Required response:
  - `Serial`=1, `Busy`=0 and `Done`=0 at the next edge.
  - A new `Send` of 8'hA5 produces a clean full frame.
- Key change after accept: `Tecla` goes from 8'h45 to 8'hFF one cycle after accept. Required response: the frame still carries 8'h45 / 8'hBA.
